sr_piso_tx: RTL and testbench
=============================

SR_PISO_TX -- requirements
Module: sr_piso_tx

Interface
REQ-001 Parameter WIDTH, default 8, word length in bits; SHALL be at least 2.
REQ-002 Parameter MSB_FIRST, default 1; 1 = transmit bit WIDTH-1 first, 0 = transmit bit 0 first.
REQ-003 clk  input  1  single clock; all registers update on the falling edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_data  input  WIDTH  parallel word to transmit.
REQ-006 in_valid  input  1  in_data is valid.
REQ-007 in_ready  output  1  block can accept a word this cycle.
REQ-008 q  output  1  serial data out.
REQ-009 q_valid  output  1  q carries a payload bit.
REQ-010 q_first  output  1  q is the first bit of a word.
REQ-011 q_last  output  1  q is the last bit of a word.
REQ-012 busy  output  1  a word is in transmission.

Function
REQ-013 Transfer SHALL occur on a falling clk edge where in_valid and in_ready are both 1; in_data SHALL be captured into an internal shift register at that edge.
REQ-014 FSM SHALL have two states: IDLE and SHIFT; IDLE->SHIFT on transfer; SHIFT->IDLE after the last bit unless a new transfer occurs on that same edge, in which case the FSM SHALL stay in SHIFT.
REQ-015 A bit counter of ceil(log2(WIDTH)) bits SHALL load 0 on transfer and increment each edge in SHIFT; the last bit is at count WIDTH-1; the counter SHALL never exceed WIDTH-1.
REQ-016 Latency: first bit SHALL appear on q (q_valid=1, q_first=1) in the cycle immediately following the transfer edge; all WIDTH bits SHALL appear on WIDTH consecutive cycles.
REQ-017 q_first SHALL be 1 only while the counter is 0 in SHIFT.
REQ-018 q_last SHALL be 1 only while the counter is WIDTH-1 in SHIFT.
REQ-019 q_valid and busy SHALL equal (state == SHIFT).
REQ-020 in_ready SHALL be combinational: 1 in IDLE, 1 in SHIFT at counter WIDTH-1, 0 otherwise.
REQ-021 Back-to-back words accepted at the last-bit cycle SHALL follow with zero gap; the first bit of the new word SHALL follow the last bit of the old word on the next cycle.
REQ-022 Changes to in_data or in_valid while in_ready=0 SHALL have no effect on q or on the captured word.
REQ-023 q SHALL be 0 whenever q_valid is 0.
REQ-024 in_valid deasserted at the last-bit cycle SHALL return the FSM to IDLE with q=0 on the next cycle.

Reset
REQ-025 While reset=1, regardless of clk: state=IDLE, counter=0, shift register=0, q=0, q_valid=0, q_first=0, q_last=0, busy=0, in_ready=1.
REQ-026 Reset asserted mid-word SHALL abort the word immediately; the remaining bits SHALL never be transmitted, and the next transfer after reset release SHALL start a fresh word.

Verification
REQ-027 Reset: assert reset with in_valid=1 -> q=0, q_valid=0, busy=0, in_ready=1 immediately; no transfer while reset=1.
REQ-028 Single word, MSB_FIRST=1, 8'hA5 -> q = 1,0,1,0,0,1,0,1 on 8 consecutive cycles; q_first on bit 1 only; q_last on bit 8 only; IDLE afterwards.
REQ-029 Back-to-back 8'hA5 then 8'h3C, in_valid held -> 16 contiguous valid bits 10100101 00111100; in_ready high only at the IDLE cycle and at each last bit.
REQ-030 Stall: in_data changed to 8'hFF during bits 2-7 of 8'h0F -> output remains 00001111; in_ready=0 during bits 1-7.
REQ-031 Mid-word reset after 3 bits of 8'hC3 -> outputs clear asynchronously; next word 8'h81 -> 10000001 with q_first on bit 1.
REQ-032 MSB_FIRST=0, 8'h01 -> q = 1,0,0,0,0,0,0,0; WIDTH=4, 4'hA -> 4 bits 1010 with q_last on bit 4.

Source files
------------

// File: rtl/sr_piso_tx_if.sv
// rtl/sr_piso_tx_if.sv - parallel word input and serial bit output bundle for sr_piso_tx
interface sr_piso_tx_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             q;
    logic             q_valid;
    logic             q_first;
    logic             q_last;
    logic             busy;

    modport master (
        output in_data, in_valid,
        input  in_ready, q, q_valid, q_first, q_last, busy
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, q, q_valid, q_first, q_last, busy
    );
endinterface

// File: rtl/sr_piso_tx.sv
// rtl/sr_piso_tx.sv - falling-edge parallel-in serial-out word transmitter
module sr_piso_tx #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    sr_piso_tx_if.slave  link
);
    localparam int             CW    = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST  = CW'(WIDTH - 1);
    localparam logic [0:0]     IDLE  = 1'b0;
    localparam logic [0:0]     SHIFT = 1'b1;

    logic [0:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sreg;
    logic             at_last;
    logic             xfer;
    logic             out_bit;

    assign at_last = (state == SHIFT) && (cnt == LAST);
    assign xfer    = link.in_valid && link.in_ready;
    assign out_bit = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];

    // A word accepted on the last-bit edge reloads in place, giving zero-gap streaming.
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            sreg  <= '0;
        end else if (xfer) begin
            state <= SHIFT;
            cnt   <= '0;
            sreg  <= link.in_data;
        end else if (state == SHIFT) begin
            if (at_last) begin
                state <= IDLE;
                cnt   <= '0;
                sreg  <= '0;
            end else begin
                cnt   <= cnt + CW'(1);
                sreg  <= MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};
            end
        end
    end

    assign link.in_ready = (state == IDLE) || at_last;
    assign link.q        = (state == SHIFT) && out_bit;
    assign link.q_valid  = (state == SHIFT);
    assign link.busy     = (state == SHIFT);
    assign link.q_first  = (state == SHIFT) && (cnt == '0);
    assign link.q_last   = at_last;
endmodule

// File: tb/tb_sr_piso_tx.sv
// tb/tb_sr_piso_tx.sv - three sr_piso_tx variants checked against a word/index reference model
module tb_sr_piso_tx;
    logic       clk;
    logic       reset;
    logic [7:0] d_data [3];
    logic       d_valid [3];
    logic [5:0] obs [3];

    int         checks;
    int         errors;

    logic [7:0] mword [3];
    int         midx  [3];

    logic [2:0] lg  [3][64];
    int         lgn [3];

    sr_piso_tx_if #(.WIDTH(8)) if0 ();
    sr_piso_tx_if #(.WIDTH(8)) if1 ();
    sr_piso_tx_if #(.WIDTH(4)) if2 ();

    sr_piso_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb8 (.clk(clk), .reset(reset), .link(if0.slave));
    sr_piso_tx #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb8 (.clk(clk), .reset(reset), .link(if1.slave));
    sr_piso_tx #(.WIDTH(4), .MSB_FIRST(1'b1)) u_msb4 (.clk(clk), .reset(reset), .link(if2.slave));

    assign if0.in_data  = d_data[0];
    assign if0.in_valid = d_valid[0];
    assign if1.in_data  = d_data[1];
    assign if1.in_valid = d_valid[1];
    assign if2.in_data  = d_data[2][3:0];
    assign if2.in_valid = d_valid[2];

    assign obs[0] = {if0.q, if0.q_valid, if0.q_first, if0.q_last, if0.busy, if0.in_ready};
    assign obs[1] = {if1.q, if1.q_valid, if1.q_first, if1.q_last, if1.busy, if1.in_ready};
    assign obs[2] = {if2.q, if2.q_valid, if2.q_first, if2.q_last, if2.busy, if2.in_ready};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int mw(input int k);
        return (k == 2) ? 4 : 8;
    endfunction

    function automatic bit mmsb(input int k);
        return (k != 1);
    endfunction

    function automatic bit mready(input int k);
        return (midx[k] < 0) || (midx[k] == mw(k) - 1);
    endfunction

    // Model: the word in flight plus the index of the bit now on the line (-1 = nothing).
    function automatic logic [5:0] exp6(input int k);
        int   i;
        logic b;
        i = midx[k];
        if (i < 0) return 6'b000001;
        b = mmsb(k) ? mword[k][mw(k) - 1 - i] : mword[k][i];
        return {b, 1'b1, (i == 0), (i == mw(k) - 1), 1'b1, (i == mw(k) - 1)};
    endfunction

    always @(negedge clk or posedge reset) begin
        for (int k = 0; k < 3; k++) begin
            if (reset) begin
                midx[k] = -1;
            end else if (d_valid[k] && mready(k)) begin
                mword[k] = d_data[k];
                midx[k]  = 0;
            end else if (midx[k] >= 0) begin
                midx[k] = (midx[k] == mw(k) - 1) ? -1 : midx[k] + 1;
            end
        end
    end

    task automatic clear_log(input int k);
        lgn[k] = 0;
        for (int i = 0; i < 64; i++) lg[k][i] = 3'b000;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic xfer(input int k, input logic [7:0] d);
        d_data[k]  = d;
        d_valid[k] = 1'b1;
        for (int t = 0; t < 40; t++) begin
            if (mready(k)) begin
                @(posedge clk);
                #1;
                d_valid[k] = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        checks++;
        errors++;
        $display("FAIL xfer_timeout dut%0d never became ready for %h", k, d);
        d_valid[k] = 1'b0;
    endtask

    task automatic check_log(input int k, input logic [15:0] exp, input int n);
        logic [15:0] oq, of, ol, ef, el;
        int w;
        w  = mw(k);
        oq = '0; of = '0; ol = '0; ef = '0; el = '0;
        for (int i = 0; i < n; i++) begin
            oq[n-1-i] = lg[k][i][2];
            of[n-1-i] = lg[k][i][1];
            ol[n-1-i] = lg[k][i][0];
            ef[n-1-i] = ((i % w) == 0);
            el[n-1-i] = ((i % w) == w - 1);
        end
        checks++;
        if (lgn[k] != n || oq != exp) begin
            errors++;
            $display("FAIL stream dut%0d got len=%0d bits=%h want len=%0d bits=%h", k, lgn[k], oq, n, exp);
        end
        checks++;
        if (of != ef) begin
            errors++;
            $display("FAIL q_first dut%0d got %b want %b", k, of, ef);
        end
        checks++;
        if (ol != el) begin
            errors++;
            $display("FAIL q_last dut%0d got %b want %b", k, ol, el);
        end
    endtask

    task automatic check_lit(input string name, input int k, input logic [5:0] want);
        checks++;
        if (obs[k] !== want) begin
            errors++;
            $display("FAIL %s dut%0d got %b want %b", name, k, obs[k], want);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            d_data[k]  = 8'h00;
            d_valid[k] = 1'b0;
            midx[k]    = -1;
            mword[k]   = 8'h00;
            clear_log(k);
        end

        fork
            forever begin
                @(posedge clk);
                for (int k = 0; k < 3; k++) begin
                    checks++;
                    if (obs[k] !== exp6(k)) begin
                        errors++;
                        $display("FAIL cycle t=%0t dut%0d got %b want %b", $time, k, obs[k], exp6(k));
                    end
                    if (obs[k][4] === 1'b1 && lgn[k] < 64) begin
                        lg[k][lgn[k]] = {obs[k][5], obs[k][3], obs[k][2]};
                        lgn[k]++;
                    end
                end
            end
        join_none

        idle(2);
        reset = 1'b0;
        idle(1);

        // Reset with in_valid high: idle outputs immediately, nothing accepted.
        for (int k = 0; k < 3; k++) d_valid[k] = 1'b1;
        reset = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) check_lit("reset_now", k, 6'b000001);
        @(negedge clk);
        #1;
        for (int k = 0; k < 3; k++) check_lit("reset_hold", k, 6'b000001);
        for (int k = 0; k < 3; k++) d_valid[k] = 1'b0;
        idle(1);
        reset = 1'b0;
        idle(1);

        clear_log(0);
        xfer(0, 8'hA5);
        idle(10);
        check_log(0, 16'h00A5, 8);
        check_lit("idle_after_a5", 0, 6'b000001);

        clear_log(0);
        xfer(0, 8'hA5);
        xfer(0, 8'h3C);
        idle(12);
        check_log(0, 16'hA53C, 16);

        // Stall: data flips to FF while not ready; valid dropped before the last bit.
        clear_log(0);
        xfer(0, 8'h0F);
        d_data[0]  = 8'hFF;
        d_valid[0] = 1'b1;
        idle(7);
        d_valid[0] = 1'b0;
        idle(4);
        check_log(0, 16'h000F, 8);

        // Mid-word reset after three bits of C3, then a fresh word.
        clear_log(0);
        xfer(0, 8'hC3);
        idle(2);
        reset = 1'b1;
        #1;
        check_lit("midword_reset", 0, 6'b000001);
        check_log(0, 16'h0006, 3);
        idle(2);
        reset = 1'b0;
        clear_log(0);
        idle(1);
        xfer(0, 8'h81);
        idle(10);
        check_log(0, 16'h0081, 8);

        clear_log(1);
        xfer(1, 8'h01);
        idle(10);
        check_log(1, 16'h0080, 8);

        clear_log(2);
        xfer(2, 8'h0A);
        idle(6);
        check_log(2, 16'h000A, 4);

        for (int it = 0; it < 400; it++) begin
            for (int k = 0; k < 3; k++) begin
                d_valid[k] = ($urandom_range(0, 9) < 7);
                d_data[k]  = 8'($urandom);
            end
            if (it == 200) reset = 1'b1;
            if (it == 203) reset = 1'b0;
            idle(1);
        end
        for (int k = 0; k < 3; k++) d_valid[k] = 1'b0;
        idle(12);
        for (int k = 0; k < 3; k++) check_lit("final_idle", k, 6'b000001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
